unidade_busca: RTL

- Instruction-fetch stage directly upstream of the control unit (UnidadeControle) in the single-cycle processor.
- Holds the program counter and fetches 16-bit instructions from an external instruction memory over a req/ack handshake.
- Presents Opcode/Funct to the control unit. Computes the next PC from the control unit's PCWrite/Jump/Cond/JumpValue outputs and the ALU Zero flag.

---
 rtl/unidade_busca.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over a req/ack
// handshake, presents Opcode/Funct to the control unit and computes NextPC.
module unidade_busca #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
    parameter int                     TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                IMemReq,
    output logic [PC_WIDTH-1:0] IMemAddr,
    input  logic                IMemAck,
    input  logic [15:0]         IMemData,
    output logic [1:0]          Opcode,
    output logic [2:0]          Funct,
    output logic [15:0]         Instr,
    output logic                InstrValid,
    input  logic                PCWrite,
    input  logic                Jump,
    input  logic                Cond,
    input  logic [1:0]          JumpValue,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] RegJumpAddr,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PCPlus1,
    output logic                Halted,
    output logic                Fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;

    // Target arithmetic; everything wraps modulo 2^PC_WIDTH.
    logic [PC_WIDTH+7:0] sext_w, zext_w;
    logic [PC_WIDTH-1:0] simm, zimm, pc_plus1, pc_branch, next_pc;

    assign sext_w    = {{PC_WIDTH{instr_q[7]}}, instr_q[7:0]};
    assign zext_w    = {{PC_WIDTH{1'b0}}, instr_q[7:0]};
    assign simm      = sext_w[PC_WIDTH-1:0];
    assign zimm      = zext_w[PC_WIDTH-1:0];
    assign pc_plus1  = pc_q + PC_WIDTH'(1);
    assign pc_branch = pc_plus1 + simm;

    // Next-PC select: Jump outranks the conditional branch.
    always_comb begin
        next_pc = pc_plus1;
        if (Jump) begin
            case (JumpValue)
                2'b00:   next_pc = pc_branch;
                2'b01:   next_pc = RegJumpAddr;
                2'b10:   next_pc = zimm;
                default: next_pc = pc_plus1;
            endcase
        end else if (Cond && Zero) begin
            next_pc = pc_branch;
        end
    end

    // Fetch/execute sequencing, wait-timeout counting and sticky status.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            S_FETCH: begin
                if (IMemAck) begin
                    instr_d = IMemData;
                    state_d = S_EXEC;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack on the threshold cycle still completes the fetch.
                if (IMemAck) begin
                    instr_d = IMemData;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (!PCWrite) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: ;  // HALT and FAULT hold everything until reset
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Request and valid are qualified by rst_n so both read 0 while reset is
    // held, even though the state register already sits in FETCH.
    assign IMemReq    = rst_n && (state_q == S_FETCH || state_q == S_WAIT);
    assign InstrValid = rst_n && (state_q == S_EXEC);
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus1    = pc_plus1;
    assign Instr      = instr_q;
    assign Opcode     = instr_q[15:14];
    assign Funct      = instr_q[13:11];
    assign Halted     = halted_q;
    assign Fault      = fault_q;

endmodule
